// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, the register-index width and the hard-wired zero register.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int SEQ_W = 3;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: decides advance / stall / flush / freeze for PC, IF/ID and ID/IX.
// Control outputs are combinational from the current state and this cycle's hazard inputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_DEPTH    = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ix_dest,
    input  logic             ix_write_to_reg,
    input  logic             ix_is_load,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             perf_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idix_we,
    output logic             idix_bubble,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [SEQ_W-1:0] LUS_INIT   = SEQ_W'(LOAD_USE_STALL - 1);
    localparam logic [SEQ_W-1:0] FLUSH_INIT = SEQ_W'(FLUSH_DEPTH - 1);

    state_t           state, next_state;
    state_t           ret_state, next_ret;
    state_t           eff_state;
    logic [SEQ_W-1:0] cnt, next_cnt;
    logic             load_use;
    logic             pc_raw, ifid_raw, idix_raw, bub_raw, flush_raw, flush_evt;

    assign load_use = ix_is_load && ix_write_to_reg && (ix_dest != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ix_dest)) || (id_uses_rt && (id_rt == ix_dest)));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= '0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
            cnt       <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_ret   = ret_state;
        next_cnt   = cnt;
        pc_raw     = 1'b1;
        ifid_raw   = 1'b1;
        idix_raw   = 1'b1;
        bub_raw    = 1'b0;
        flush_raw  = 1'b0;
        flush_evt  = 1'b0;
        // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
        eff_state  = (state == MEM_WAIT) ? ret_state : state;
        if (mem_busy) begin
            pc_raw     = 1'b0;
            ifid_raw   = 1'b0;
            idix_raw   = 1'b0;
            next_state = MEM_WAIT;
            if (state != MEM_WAIT) next_ret = state;
        end else begin
            next_state = eff_state;
            case (eff_state)
                FLUSH: begin
                    flush_raw = 1'b1;
                    bub_raw   = 1'b1;
                    next_cnt  = cnt - SEQ_W'(1);
                    if (next_cnt == '0) next_state = RUN;
                end
                default: begin
                    if (branch_taken) begin
                        flush_raw = 1'b1;
                        bub_raw   = 1'b1;
                        flush_evt = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            next_state = FLUSH;
                            next_cnt   = FLUSH_INIT;
                        end else begin
                            next_state = RUN;
                            next_cnt   = '0;
                        end
                    end else if (eff_state == LD_STALL) begin
                        pc_raw   = 1'b0;
                        ifid_raw = 1'b0;
                        bub_raw  = 1'b1;
                        next_cnt = cnt - SEQ_W'(1);
                        if (next_cnt == '0) next_state = RUN;
                    end else if (load_use) begin
                        pc_raw   = 1'b0;
                        ifid_raw = 1'b0;
                        bub_raw  = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            next_state = LD_STALL;
                            next_cnt   = LUS_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // Reset overrides the decoded controls so the pipeline holds with a bubble in ID/IX.
    assign pc_we       = rst_b & pc_raw;
    assign ifid_we     = rst_b & ifid_raw;
    assign idix_we     = rst_b & idix_raw;
    assign ifid_flush  = rst_b & flush_raw;
    assign idix_bubble = ~rst_b | bub_raw;
    assign state_out   = rst_b ? state : RUN;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (~pc_we),
        .clr   (perf_clr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (flush_evt),
        .clr   (perf_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (short-sequence/narrow counters and longer sequences)
// share one stimulus stream and are compared against a cycle-count model of the hazard rules.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [4:0] id_rs, id_rt, ix_dest;
    logic       id_uses_rs, id_uses_rt, ix_write_to_reg, ix_is_load;
    logic       branch_taken, mem_busy, perf_clr;

    logic        pc_we_o[2], ifid_we_o[2], ifid_flush_o[2], idix_we_o[2], idix_bubble_o[2];
    logic [1:0]  state_o[2];
    logic [3:0]  stall_a, flush_a;
    logic [15:0] stall_b, flush_b;
    logic [15:0] scnt_o[2], fcnt_o[2];

    assign scnt_o[0] = {12'd0, stall_a};
    assign fcnt_o[0] = {12'd0, flush_a};
    assign scnt_o[1] = stall_b;
    assign fcnt_o[1] = flush_b;

    int total = 0;
    int bad = 0;

    // model: remaining bubble cycles of each kind, whether last cycle was frozen, counters
    int          lus[2]  = '{1, 3};
    int          fd[2]   = '{1, 2};
    int          cmax[2] = '{15, 65535};
    int          sl[2], fl[2];
    logic        bp[2];
    logic [15:0] sc[2], fc[2];
    logic        e_pc[2], e_ifid[2], e_idix[2], e_bub[2], e_flush[2];
    logic [1:0]  e_state[2];
    logic [15:0] e_sc[2], e_fc[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .FLUSH_DEPTH(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ix_dest(ix_dest), .ix_write_to_reg(ix_write_to_reg),
        .ix_is_load(ix_is_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .perf_clr(perf_clr), .pc_we(pc_we_o[0]), .ifid_we(ifid_we_o[0]),
        .ifid_flush(ifid_flush_o[0]), .idix_we(idix_we_o[0]), .idix_bubble(idix_bubble_o[0]),
        .state_out(state_o[0]), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_hazard_ctrl #(.LOAD_USE_STALL(3), .FLUSH_DEPTH(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ix_dest(ix_dest), .ix_write_to_reg(ix_write_to_reg),
        .ix_is_load(ix_is_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .perf_clr(perf_clr), .pc_we(pc_we_o[1]), .ifid_we(ifid_we_o[1]),
        .ifid_flush(ifid_flush_o[1]), .idix_we(idix_we_o[1]), .idix_bubble(idix_bubble_o[1]),
        .state_out(state_o[1]), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ix_dest = 0;
        id_uses_rs = 0; id_uses_rt = 0; ix_write_to_reg = 0; ix_is_load = 0;
        branch_taken = 0; mem_busy = 0; perf_clr = 0;
    endtask

    task automatic set_hazard(input logic [4:0] r);
        ix_is_load = 1; ix_write_to_reg = 1; ix_dest = r; id_rs = r; id_uses_rs = 1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Waits for the falling edge, produces this cycle's expectations and steps the model.
    task automatic sample();
        logic lu;
        logic s_inc, f_inc;
        @(negedge clk);
        lu = ix_is_load && ix_write_to_reg && (ix_dest != 0) &&
             ((id_uses_rs && id_rs == ix_dest) || (id_uses_rt && id_rt == ix_dest));
        for (int k = 0; k < 2; k++) begin
            s_inc = 0; f_inc = 0;
            if (!rst_b) begin
                e_pc[k] = 0; e_ifid[k] = 0; e_idix[k] = 0; e_bub[k] = 1; e_flush[k] = 0;
                e_state[k] = 0; sl[k] = 0; fl[k] = 0; bp[k] = 0; sc[k] = 0; fc[k] = 0;
                e_sc[k] = 0; e_fc[k] = 0;
                continue;
            end
            e_sc[k] = sc[k];
            e_fc[k] = fc[k];
            e_state[k] = bp[k] ? 2'd3 : (sl[k] > 0) ? 2'd1 : (fl[k] > 0) ? 2'd2 : 2'd0;
            if (mem_busy) begin
                e_pc[k] = 0; e_ifid[k] = 0; e_idix[k] = 0; e_bub[k] = 0; e_flush[k] = 0;
                bp[k] = 1; s_inc = 1;
            end else begin
                bp[k] = 0;
                e_pc[k] = 1; e_ifid[k] = 1; e_idix[k] = 1; e_bub[k] = 0; e_flush[k] = 0;
                if (fl[k] > 0) begin
                    e_flush[k] = 1; e_bub[k] = 1; fl[k]--;
                end else if (branch_taken) begin
                    e_flush[k] = 1; e_bub[k] = 1; fl[k] = fd[k] - 1; sl[k] = 0; f_inc = 1;
                end else if (sl[k] > 0 || lu) begin
                    e_pc[k] = 0; e_ifid[k] = 0; e_bub[k] = 1; s_inc = 1;
                    sl[k] = (sl[k] > 0) ? sl[k] - 1 : lus[k] - 1;
                end
            end
            if (perf_clr) begin
                sc[k] = 0; fc[k] = 0;
            end else begin
                if (s_inc && int'(sc[k]) < cmax[k]) sc[k] = sc[k] + 1;
                if (f_inc && int'(fc[k]) < cmax[k]) fc[k] = fc[k] + 1;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_b = 0;
        repeat (2) advance();
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if (pc_we_o[k] !== 1'b0) begin bad++; $display("FAIL reset_pc_we[%0d] got=%b exp=0", k, pc_we_o[k]); end
            total++; if (ifid_we_o[k] !== 1'b0) begin bad++; $display("FAIL reset_ifid_we[%0d] got=%b exp=0", k, ifid_we_o[k]); end
            total++; if (idix_we_o[k] !== 1'b0) begin bad++; $display("FAIL reset_idix_we[%0d] got=%b exp=0", k, idix_we_o[k]); end
            total++; if (idix_bubble_o[k] !== 1'b1) begin bad++; $display("FAIL reset_bubble[%0d] got=%b exp=1", k, idix_bubble_o[k]); end
            total++; if (ifid_flush_o[k] !== 1'b0) begin bad++; $display("FAIL reset_flush[%0d] got=%b exp=0", k, ifid_flush_o[k]); end
            total++; if (state_o[k] !== 2'd0) begin bad++; $display("FAIL reset_state[%0d] got=%0d exp=0", k, state_o[k]); end
            total++; if (scnt_o[k] !== 16'd0 || fcnt_o[k] !== 16'd0) begin
                bad++; $display("FAIL reset_counters[%0d] got=%0d/%0d exp=0/0", k, scnt_o[k], fcnt_o[k]);
            end
        end
        advance();
        rst_b = 1;
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if ({pc_we_o[k], ifid_we_o[k], idix_we_o[k], idix_bubble_o[k]} !== 4'b1110) begin
                bad++; $display("FAIL release_run[%0d] got pc/ifid/idix/bub=%b%b%b%b exp=1110", k,
                                pc_we_o[k], ifid_we_o[k], idix_we_o[k], idix_bubble_o[k]);
            end
        end
        advance();
    endtask

    task automatic test_load_use();
        set_hazard(5'd5);
        sample();
        total++; if ({pc_we_o[0], ifid_we_o[0], idix_we_o[0], idix_bubble_o[0]} !== 4'b0011) begin
            bad++; $display("FAIL lu_stall got pc/ifid/idix/bub=%b%b%b%b exp=0011",
                            pc_we_o[0], ifid_we_o[0], idix_we_o[0], idix_bubble_o[0]);
        end
        advance();
        clear_inputs();
        sample();
        total++; if (pc_we_o[0] !== 1'b1) begin bad++; $display("FAIL lu_single got pc_we=%b exp=1", pc_we_o[0]); end
        total++; if (stall_a !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_a); end
        advance();
        repeat (3) begin sample(); advance(); end
        set_hazard(5'd0);
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if (pc_we_o[k] !== 1'b1 || idix_bubble_o[k] !== 1'b0) begin
                bad++; $display("FAIL lu_reg0[%0d] got pc_we=%b bub=%b exp=1/0", k, pc_we_o[k], idix_bubble_o[k]);
            end
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_ld_stall3();
        logic [1:0] st_seq[4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        logic       pc_seq[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        perf_clr = 1; sample(); advance(); perf_clr = 0;
        set_hazard(5'd7);
        for (int i = 0; i < 4; i++) begin
            sample();
            total++; if (state_o[1] !== st_seq[i] || pc_we_o[1] !== pc_seq[i]) begin
                bad++; $display("FAIL ld3_seq[%0d] got state=%0d pc_we=%b exp=%0d/%b", i, state_o[1], pc_we_o[1], st_seq[i], pc_seq[i]);
            end
            advance();
            clear_inputs();
        end
        sample();
        total++; if (stall_b !== 16'd3) begin bad++; $display("FAIL ld3_stall_cnt got=%0d exp=3", stall_b); end
        advance();
    endtask

    task automatic test_branch();
        perf_clr = 1; sample(); advance(); perf_clr = 0;
        set_hazard(5'd9);
        branch_taken = 1;
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if ({ifid_flush_o[k], pc_we_o[k], idix_bubble_o[k]} !== 3'b111) begin
                bad++; $display("FAIL br_win[%0d] got flush/pc/bub=%b%b%b exp=111", k, ifid_flush_o[k], pc_we_o[k], idix_bubble_o[k]);
            end
        end
        advance();
        clear_inputs();
        sample();
        total++; if (ifid_flush_o[1] !== 1'b1 || state_o[1] !== 2'd2) begin
            bad++; $display("FAIL br_depth2 got flush=%b state=%0d exp=1/2", ifid_flush_o[1], state_o[1]);
        end
        total++; if (ifid_flush_o[0] !== 1'b0) begin bad++; $display("FAIL br_depth1 got flush=%b exp=0", ifid_flush_o[0]); end
        advance();
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if (fcnt_o[k] !== 16'd1 || scnt_o[k] !== 16'd0) begin
                bad++; $display("FAIL br_counts[%0d] got flush_cnt=%0d stall_cnt=%0d exp=1/0", k, fcnt_o[k], scnt_o[k]);
            end
        end
        advance();
    endtask

    task automatic test_mem_wait();
        perf_clr = 1; sample(); advance(); perf_clr = 0;
        set_hazard(5'd3);
        sample(); advance();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            total++; if ({pc_we_o[1], ifid_we_o[1], idix_we_o[1], idix_bubble_o[1], ifid_flush_o[1]} !== 5'b0) begin
                bad++; $display("FAIL mw_frozen[%0d] got pc/ifid/idix/bub/fl=%b%b%b%b%b exp=00000", i,
                                pc_we_o[1], ifid_we_o[1], idix_we_o[1], idix_bubble_o[1], ifid_flush_o[1]);
            end
            if (i > 0) begin
                total++; if (state_o[1] !== 2'd3) begin bad++; $display("FAIL mw_state[%0d] got=%0d exp=3", i, state_o[1]); end
            end
            advance();
        end
        mem_busy = 0;
        for (int i = 0; i < 2; i++) begin
            sample();
            total++; if (pc_we_o[1] !== 1'b0 || idix_bubble_o[1] !== 1'b1) begin
                bad++; $display("FAIL mw_resume[%0d] got pc_we=%b bub=%b exp=0/1", i, pc_we_o[1], idix_bubble_o[1]);
            end
            advance();
        end
        sample();
        total++; if (pc_we_o[1] !== 1'b1 || stall_b !== 16'd7) begin
            bad++; $display("FAIL mw_done got pc_we=%b stall_cnt=%0d exp=1/7", pc_we_o[1], stall_b);
        end
        advance();
    endtask

    task automatic test_saturate();
        mem_busy = 1;
        repeat (20) begin sample(); advance(); end
        sample();
        total++; if (stall_a !== 4'hf) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_a); end
        advance();
        perf_clr = 1;
        sample();
        total++; if (stall_a !== 4'hf) begin bad++; $display("FAIL sat_stay got=%0d exp=15", stall_a); end
        advance();
        clear_inputs();
        sample();
        for (int k = 0; k < 2; k++) begin
            total++; if (scnt_o[k] !== 16'd0) begin bad++; $display("FAIL sat_clr[%0d] got=%0d exp=0", k, scnt_o[k]); end
        end
        advance();
    endtask

    task automatic test_reset_mid();
        set_hazard(5'd4);
        sample(); advance();
        clear_inputs();
        #2 rst_b = 0;
        sample();
        total++; if (state_o[1] !== 2'd0 || pc_we_o[1] !== 1'b0) begin
            bad++; $display("FAIL rstmid_hold got state=%0d pc_we=%b exp=0/0", state_o[1], pc_we_o[1]);
        end
        advance();
        rst_b = 1;
        sample();
        total++; if (state_o[1] !== 2'd0 || pc_we_o[1] !== 1'b1 || idix_bubble_o[1] !== 1'b0) begin
            bad++; $display("FAIL rstmid_abandon got state=%0d pc_we=%b bub=%b exp=0/1/0", state_o[1], pc_we_o[1], idix_bubble_o[1]);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ix_dest = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            ix_is_load = ($urandom_range(0, 99) < 60);
            ix_write_to_reg = ($urandom_range(0, 99) < 80);
            branch_taken = ($urandom_range(0, 99) < 15);
            mem_busy = ($urandom_range(0, 99) < 15);
            perf_clr = ($urandom_range(0, 99) < 3);
            sample();
            for (int k = 0; k < 2; k++) begin
                total++; if ({pc_we_o[k], ifid_we_o[k], idix_we_o[k], idix_bubble_o[k], ifid_flush_o[k]} !==
                             {e_pc[k], e_ifid[k], e_idix[k], e_bub[k], e_flush[k]}) begin
                    bad++; $display("FAIL rnd_ctl[%0d] n=%0d got pc/ifid/idix/bub/fl=%b%b%b%b%b exp=%b%b%b%b%b", k, n,
                                    pc_we_o[k], ifid_we_o[k], idix_we_o[k], idix_bubble_o[k], ifid_flush_o[k],
                                    e_pc[k], e_ifid[k], e_idix[k], e_bub[k], e_flush[k]);
                end
                total++; if (state_o[k] !== e_state[k]) begin
                    bad++; $display("FAIL rnd_state[%0d] n=%0d got=%0d exp=%0d", k, n, state_o[k], e_state[k]);
                end
                total++; if (scnt_o[k] !== e_sc[k] || fcnt_o[k] !== e_fc[k]) begin
                    bad++; $display("FAIL rnd_cnt[%0d] n=%0d got=%0d/%0d exp=%0d/%0d", k, n, scnt_o[k], fcnt_o[k], e_sc[k], e_fc[k]);
                end
            end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_ld_stall3();
        test_branch();
        test_mem_wait();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
